// File: rtl/te_dispatch_pkg.sv
// Shared definitions for the tracking-engine channel dispatcher:
// channel count, index width, dispatcher state encoding and a popcount helper.
package te_dispatch_pkg;

    localparam int CH_NUM = 32;
    localparam int CH_W   = 5;

    // Legacy-compatible state codes; the enum below reuses them.
    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_OFFER = 1'b1;

    typedef enum logic [0:0] {
        IDLE  = ST_IDLE,
        OFFER = ST_OFFER
    } disp_state_e;

    // Number of set bits in a channel mask (0..32, hence CH_W+1 bits).
    function automatic logic [CH_W:0] popcount32(input logic [CH_NUM-1:0] v);
        logic [CH_W:0] c;
        c = '0;
        for (int i = 0; i < CH_NUM; i++) begin
            c = c + {{CH_W{1'b0}}, v[i]};
        end
        return c;
    endfunction

endpackage

// File: rtl/onehot_decode32.sv
// 5-bit channel index to 32-bit one-hot mask, purely combinational.
module onehot_decode32
    import te_dispatch_pkg::*;
(
    input  logic [CH_W-1:0]   idx,
    output logic [CH_NUM-1:0] onehot
);

    // Shift a single bit into the indexed position.
    assign onehot = {{(CH_NUM-1){1'b0}}, 1'b1} << idx;

endmodule

// File: rtl/channel_dispatch32.sv
// Pending-request dispatcher for 32 tracking channels.
// Latches request pulses into a pending mask, offers one pending channel at a
// time on a valid/ready port and clears its bit on acceptance.
// Optional feature: define CHANNEL_DISPATCH_RR_EN for round-robin selection;
// without it the lowest pending channel always wins.
//
// Handshake: disp_valid/disp_channel are raised together and held unchanged
// until the edge where disp_ready is also high; that edge is the transfer.
// An offer is never withdrawn, even if its pending bit is cancelled meanwhile.
module channel_dispatch32
    import te_dispatch_pkg::*;
(
    input  logic              clk,
    input  logic              rst_b,
    input  logic [CH_NUM-1:0] req_set,
    input  logic [CH_NUM-1:0] req_clr,
    input  logic              enable,
    input  logic              disp_ready,
    output logic              disp_valid,
    output logic [CH_W-1:0]   disp_channel,
    output logic [CH_NUM-1:0] pending,
    output logic [CH_W:0]     pending_count,
    output logic              dup_set
);

    disp_state_e       state;
    logic              handshake;
    logic [CH_NUM-1:0] hs_onehot;
    logic [CH_NUM-1:0] hs_clr;
    logic [CH_NUM-1:0] pend_next;
    logic              dup_next;
    logic [CH_W-1:0]   lsb_all;
    logic [CH_W-1:0]   search_ch;

    assign disp_valid = (state == OFFER);
    assign handshake  = disp_valid & disp_ready;

    onehot_decode32 u_hs_dec (
        .idx    (disp_channel),
        .onehot (hs_onehot)
    );

    assign hs_clr = handshake ? hs_onehot : '0;

    // Set, then cancel (cancel beats set), then handshake clear unless a fresh
    // set to the same bit arrives this cycle.
    assign pend_next = ((pending | req_set) & ~req_clr) & ~(hs_clr & ~req_set);

    // A set that lands on a bit that stays pending is a duplicate request.
    assign dup_next = |(req_set & pending & ~req_clr & ~hs_clr);

    // Lowest set bit of the whole pending mask (scan high to low, last hit wins).
    always_comb begin
        lsb_all = '0;
        for (int i = CH_NUM - 1; i >= 0; i--) begin
            if (pending[i]) lsb_all = CH_W'(i);
        end
    end

`ifdef CHANNEL_DISPATCH_RR_EN
    logic [CH_W-1:0]   last_grant;
    logic [CH_NUM-1:0] lg_onehot;
    logic [CH_NUM-1:0] pend_above;
    logic [CH_W-1:0]   lsb_above;

    onehot_decode32 u_rr_dec (
        .idx    (last_grant),
        .onehot (lg_onehot)
    );

    // Only channels strictly above the last grant get first pick.
    assign pend_above = pending & ~(lg_onehot | (lg_onehot - 1'b1));

    // Lowest set bit above the pointer; wrap to the overall lowest if none.
    always_comb begin
        lsb_above = '0;
        for (int i = CH_NUM - 1; i >= 0; i--) begin
            if (pend_above[i]) lsb_above = CH_W'(i);
        end
        search_ch = (|pend_above) ? lsb_above : lsb_all;
    end

    // Pointer follows each accepted channel; reset value 31 starts at bit 0.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            last_grant <= CH_W'(CH_NUM - 1);
        end else if (handshake) begin
            last_grant <= disp_channel;
        end
    end
`else
    assign search_ch = lsb_all;
`endif

    // Offer state machine: start an offer from IDLE, hold it until accepted.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state        <= IDLE;
            disp_channel <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (enable && (|pending)) begin
                        disp_channel <= search_ch;
                        state        <= OFFER;
                    end
                end
                OFFER: begin
                    if (disp_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Pending mask, its popcount and the duplicate-request pulse.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            pending       <= '0;
            pending_count <= '0;
            dup_set       <= 1'b0;
        end else begin
            pending       <= pend_next;
            pending_count <= popcount32(pend_next);
            dup_set       <= dup_next;
        end
    end

endmodule

// File: tb/tb_channel_dispatch32.sv
// Self-checking bench for channel_dispatch32: per-cycle vector table plus
// hand-written sequences for ordering and asynchronous reset.
module tb_channel_dispatch32;

    logic        clk;
    logic        rst_b;
    logic [31:0] req_set;
    logic [31:0] req_clr;
    logic        enable;
    logic        disp_ready;
    logic        disp_valid;
    logic [4:0]  disp_channel;
    logic [31:0] pending;
    logic [5:0]  pending_count;
    logic        dup_set;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [4:0] exp_q[$];
    int         hs_cyc[$];

    typedef struct {
        logic [31:0] set;
        logic [31:0] clr;
        logic        en;
        logic        rdy;
        logic        hs;
        logic [4:0]  hs_ch;
        logic        valid;
        logic [4:0]  ch;
        logic [31:0] pend;
        logic [5:0]  cnt;
        logic        dup;
    } vec_t;

    vec_t vecs[$];

    channel_dispatch32 dut (
        .clk           (clk),
        .rst_b         (rst_b),
        .req_set       (req_set),
        .req_clr       (req_clr),
        .enable        (enable),
        .disp_ready    (disp_ready),
        .disp_valid    (disp_valid),
        .disp_channel  (disp_channel),
        .pending       (pending),
        .pending_count (pending_count),
        .dup_set       (dup_set)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard: every accepted offer must match the next expected channel.
    always @(negedge clk) begin
        logic [4:0] e;
        cyc++;
        if (rst_b && disp_valid && disp_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL dispatch_unexpected: got ch=%0d, expected no dispatch", disp_channel);
            end else begin
                e = exp_q.pop_front();
                if (disp_channel !== e) begin
                    errors++;
                    $display("FAIL dispatch_order: got ch=%0d, expected ch=%0d", disp_channel, e);
                end
            end
            hs_cyc.push_back(cyc);
        end
    end

    // Driver tasks
    task automatic drive(input logic [31:0] s, input logic [31:0] c,
                         input logic en, input logic rdy);
        req_set    = s;
        req_clr    = c;
        enable     = en;
        disp_ready = rdy;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic [31:0] s, input logic [31:0] c, input logic en,
                       input logic rdy, input logic hs, input logic [4:0] hs_ch,
                       input logic valid, input logic [4:0] ch, input logic [31:0] pend,
                       input logic [5:0] cnt, input logic dup);
        vec_t v;
        v.set = s; v.clr = c; v.en = en; v.rdy = rdy; v.hs = hs; v.hs_ch = hs_ch;
        v.valid = valid; v.ch = ch; v.pend = pend; v.cnt = cnt; v.dup = dup;
        vecs.push_back(v);
    endtask

    task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
        end
    endtask

    initial begin
        logic [4:0]  order[3];
        logic [5:0]  cnt_exp[6];
        int          n_hs;
        int          waited;

        drive('0, '0, 1'b1, 1'b1);
        rst_b = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_b = 1'b1;
        step();

        // Reset state
        check_val("reset_valid", {31'b0, disp_valid}, 32'h0);
        check_val("reset_channel", {27'b0, disp_channel}, 32'h0);
        check_val("reset_pending", pending, 32'h0);
        check_val("reset_count", {26'b0, pending_count}, 32'h0);
        check_val("reset_dup", {31'b0, dup_set}, 32'h0);

        // set, clr, en, rdy, hs, hs_ch, valid, ch, pend, cnt, dup
        // Single request round trip
        add(32'h1, 0, 1, 1, 0, 0, 0, 0, 32'h1, 1, 0);
        add(0, 0, 1, 1, 0, 0, 1, 0, 32'h1, 1, 0);
        add(0, 0, 1, 1, 1, 0, 0, 0, 32'h0, 0, 0);
        add(0, 0, 1, 1, 0, 0, 0, 0, 32'h0, 0, 0);
        // Three requests, ready held high: 0, 4, 31 two cycles apart
        add(32'h8000_0011, 0, 1, 1, 0, 0, 0, 0, 32'h8000_0011, 3, 0);
        add(0, 0, 1, 1, 0, 0, 1, 0, 32'h8000_0011, 3, 0);
        add(0, 0, 1, 1, 1, 0, 0, 0, 32'h8000_0010, 2, 0);
        add(0, 0, 1, 1, 0, 0, 1, 4, 32'h8000_0010, 2, 0);
        add(0, 0, 1, 1, 1, 4, 0, 0, 32'h8000_0000, 1, 0);
        add(0, 0, 1, 1, 0, 0, 1, 31, 32'h8000_0000, 1, 0);
        add(0, 0, 1, 1, 1, 31, 0, 0, 32'h0, 0, 0);
        add(0, 0, 1, 1, 0, 0, 0, 0, 32'h0, 0, 0);
        // Duplicate set, then set racing the handshake of the same channel
        add(32'h80, 0, 1, 0, 0, 0, 0, 0, 32'h80, 1, 0);
        add(32'h80, 0, 1, 0, 0, 0, 1, 7, 32'h80, 1, 1);
        add(0, 0, 1, 0, 0, 0, 1, 7, 32'h80, 1, 0);
        add(32'h80, 0, 1, 1, 1, 7, 0, 0, 32'h80, 1, 0);
        add(0, 0, 1, 0, 0, 0, 1, 7, 32'h80, 1, 0);
        add(0, 0, 1, 1, 1, 7, 0, 0, 32'h0, 0, 0);
        add(0, 0, 1, 1, 0, 0, 0, 0, 32'h0, 0, 0);
        // Cancel of the offered channel: offer held, no re-offer
        add(32'h20, 0, 1, 0, 0, 0, 0, 0, 32'h20, 1, 0);
        add(0, 0, 1, 0, 0, 0, 1, 5, 32'h20, 1, 0);
        add(0, 32'h20, 1, 0, 0, 0, 1, 5, 32'h0, 0, 0);
        add(0, 0, 1, 0, 0, 0, 1, 5, 32'h0, 0, 0);
        add(0, 0, 1, 1, 1, 5, 0, 0, 32'h0, 0, 0);
        add(0, 0, 1, 1, 0, 0, 0, 0, 32'h0, 0, 0);
        // Enable gating: blocks new offers only
        add(32'h3, 0, 0, 0, 0, 0, 0, 0, 32'h3, 2, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0, 32'h3, 2, 0);
        add(0, 0, 1, 0, 0, 0, 1, 0, 32'h3, 2, 0);
        add(0, 0, 0, 0, 0, 0, 1, 0, 32'h3, 2, 0);
        add(0, 0, 0, 1, 1, 0, 0, 0, 32'h2, 1, 0);
        add(0, 0, 0, 1, 0, 0, 0, 0, 32'h2, 1, 0);
        add(0, 0, 1, 1, 0, 0, 1, 1, 32'h2, 1, 0);
        add(0, 0, 1, 1, 1, 1, 0, 0, 32'h0, 0, 0);
        // Clear beats set on the same bit
        add(32'h200, 32'h200, 1, 1, 0, 0, 0, 0, 32'h0, 0, 0);
        add(0, 0, 1, 1, 0, 0, 0, 0, 32'h0, 0, 0);
        // All-ones in, all-zeros out
        add(32'hFFFF_FFFF, 0, 0, 0, 0, 0, 0, 0, 32'hFFFF_FFFF, 32, 0);
        add(0, 32'hFFFF_FFFF, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0);
        add(0, 0, 1, 0, 0, 0, 0, 0, 32'h0, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].set, vecs[i].clr, vecs[i].en, vecs[i].rdy);
            if (vecs[i].hs) exp_q.push_back(vecs[i].hs_ch);
            step();
            checks++;
            if (disp_valid !== vecs[i].valid || pending !== vecs[i].pend ||
                pending_count !== vecs[i].cnt || dup_set !== vecs[i].dup ||
                (vecs[i].valid && disp_channel !== vecs[i].ch)) begin
                errors++;
                $display("FAIL vec%0d: got valid=%0b ch=%0d pend=%08h cnt=%0d dup=%0b, expected valid=%0b ch=%0d pend=%08h cnt=%0d dup=%0b",
                         i, disp_valid, disp_channel, pending, pending_count, dup_set,
                         vecs[i].valid, vecs[i].ch, vecs[i].pend, vecs[i].cnt, vecs[i].dup);
            end
        end

        // Ordering after a prior grant of channel 4
        drive(32'h10, 0, 1, 1);
        exp_q.push_back(5'd4);
        step();
        drive(0, 0, 1, 1);
        step();
        step();
`ifdef CHANNEL_DISPATCH_RR_EN
        order[0] = 5'd31; order[1] = 5'd0; order[2] = 5'd4;
`else
        order[0] = 5'd0; order[1] = 5'd4; order[2] = 5'd31;
`endif
        for (int k = 0; k < 3; k++) exp_q.push_back(order[k]);
        hs_cyc.delete();
        cnt_exp[0] = 6'd3; cnt_exp[1] = 6'd2; cnt_exp[2] = 6'd2;
        cnt_exp[3] = 6'd1; cnt_exp[4] = 6'd1; cnt_exp[5] = 6'd0;
        drive(32'h8000_0011, 0, 1, 1);
        step();
        drive(0, 0, 1, 1);
        for (int k = 0; k < 6; k++) begin
            step();
            check_val($sformatf("order_count%0d", k), {26'b0, pending_count}, {26'b0, cnt_exp[k]});
        end
        n_hs = hs_cyc.size();
        check_val("order_hs_count", n_hs, 3);
        if (n_hs == 3) begin
            check_val("order_gap1", hs_cyc[1] - hs_cyc[0], 2);
            check_val("order_gap2", hs_cyc[2] - hs_cyc[1], 2);
        end

        // Asynchronous reset in the middle of an offer
        drive(32'hFFFF_FFFF, 0, 1, 0);
        step();
        drive(0, 0, 1, 0);
        waited = 0;
        while (!disp_valid && waited < 10) begin
            step();
            waited++;
        end
        check_val("rst_offer_seen", {31'b0, disp_valid}, 32'h1);
        #2;
        rst_b = 1'b0;
        #1;
        check_val("rst_async_valid", {31'b0, disp_valid}, 32'h0);
        check_val("rst_async_pending", pending, 32'h0);
        check_val("rst_async_count", {26'b0, pending_count}, 32'h0);
        check_val("rst_async_chan_dup", {26'b0, disp_channel, dup_set}, 32'h0);
        @(negedge clk);
        rst_b = 1'b1;
        drive(0, 0, 1, 1);
        repeat (3) step();
        check_val("rst_no_offer", {31'b0, disp_valid}, 32'h0);
        drive(32'h0010_0001, 0, 1, 0);
        step();
        drive(0, 0, 1, 0);
        step();
        check_val("rst_first_offer", {26'b0, disp_valid, disp_channel}, {26'b0, 1'b1, 5'd0});
        drive(0, 0, 1, 1);
        exp_q.push_back(5'd0);
        step();
        drive(0, 0, 0, 0);
        step();

        check_val("scoreboard_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
